// File: rtl/bf2_input_pair.sv
`default_nettype none
// ============================================================================
// Module      : bf2_input_pair
// Description : Input commutator for one radix-2 FFT stage. Buffers the first
//               D samples of each 2*D-sample block. Each later sample is then
//               presented with the sample D positions before it as an (a, b)
//               operand pair for a downstream butterfly2 stage.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : WIDTH      - bits per real/imag component (signed)
//               DEPTH_LOG2 - log2 of pair distance D (D = 2**DEPTH_LOG2, >= 1)
// Ports       : CLK        in   clock, rising edge
//               RST        in   asynchronous active-low reset
//               valid_i    in   input sample present
//               ce         in   clock enable; low holds all state
//               sof_i      in   start-of-frame (only with BF2_PAIR_SOF_EN)
//               dr, di     in   input sample real / imaginary
//               valid_o    out  operand pair valid (registered)
//               ar, ai     out  earlier sample x[k] (registered)
//               br, bi     out  later sample x[k+D] (registered)
//               k_o        out  pair index k (registered)
// Options     : BF2_PAIR_SOF_EN - adds sof_i; an accepted sample with sof_i=1
//               restarts the block with that sample at index 0.
// ============================================================================
module bf2_input_pair #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  valid_i,
  input  logic                  ce,
`ifdef BF2_PAIR_SOF_EN
  input  logic                  sof_i,
`endif
  input  logic [WIDTH-1:0]      dr,
  input  logic [WIDTH-1:0]      di,
  output logic                  valid_o,
  output logic [WIDTH-1:0]      ar,
  output logic [WIDTH-1:0]      ai,
  output logic [WIDTH-1:0]      br,
  output logic [WIDTH-1:0]      bi,
  output logic [DEPTH_LOG2-1:0] k_o
);

  localparam int                c_depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_one = {{DEPTH_LOG2{1'b0}}, 1'b1};

  // The state is the MSB of the block sample counter; r_idx holds the low
  // bits, i.e. the buffer slot (FILL) or pair index k (PAIR).
  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_PAIR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DEPTH_LOG2-1:0] w_idx_nxt;
  logic [DEPTH_LOG2-1:0] w_widx;
  logic [DEPTH_LOG2:0]   w_cnt_nxt;
  logic                  w_accept;
  logic                  w_sof;
  logic                  w_write;
  logic                  w_emit;
  logic [2*WIDTH-1:0]    r_buf [c_depth];

  assign w_accept = valid_i & ce;

`ifdef BF2_PAIR_SOF_EN
  assign w_sof = w_accept & sof_i;
`else
  assign w_sof = 1'b0;
`endif

  // Next-state / control decode
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = {r_state == S_PAIR, r_idx};
    w_write     = 1'b0;
    w_emit      = 1'b0;
    w_widx      = r_idx;
    if (w_accept) begin
      if (w_sof) begin
        // Restart: this sample becomes index 0, counter resumes at 1.
        w_cnt_nxt = c_one;
        w_write   = 1'b1;
        w_widx    = '0;
      end else begin
        // Counter width is exactly log2(2*D), so the add wraps for free.
        w_cnt_nxt = {r_state == S_PAIR, r_idx} + c_one;
        w_write   = (r_state == S_FILL);
        w_emit    = (r_state == S_PAIR);
      end
      w_state_nxt = w_cnt_nxt[DEPTH_LOG2] ? S_PAIR : S_FILL;
      w_idx_nxt   = w_cnt_nxt[DEPTH_LOG2-1:0];
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_FILL;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Sample buffer: contents survive reset; stale data is never paired
  // because the counter restarts in FILL and overwrites before reading.
  always_ff @(posedge CLK) begin
    if (w_write) begin
      r_buf[w_widx] <= {dr, di};
    end
  end

  // Output registers: the pair read uses the pre-update slot r_idx, which
  // is the same-cycle read of buffer[cnt-D].
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_o <= 1'b0;
      ar      <= '0;
      ai      <= '0;
      br      <= '0;
      bi      <= '0;
      k_o     <= '0;
    end else if (ce) begin
      valid_o <= w_emit;
      if (w_emit) begin
        ar  <= r_buf[r_idx][2*WIDTH-1:WIDTH];
        ai  <= r_buf[r_idx][WIDTH-1:0];
        br  <= dr;
        bi  <= di;
        k_o <= r_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bf2_input_pair.sv
`default_nettype none
// ============================================================================
// Module      : tb_bf2_input_pair
// Description : Self-checking bench for bf2_input_pair. A block-position
//               reference model built from queues predicts every output
//               each cycle; directed and random streams drive the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bf2_input_pair;

  localparam int W  = 8;
  localparam int DL = 2;
  localparam int D  = 1 << DL;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          valid_i = 1'b0;
  logic          ce = 1'b0;
  logic          sof_i = 1'b0;
  logic [W-1:0]  dr = '0;
  logic [W-1:0]  di = '0;
  logic          valid_o;
  logic [W-1:0]  ar, ai, br, bi;
  logic [DL-1:0] k_o;

  bf2_input_pair #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .valid_i (valid_i),
    .ce      (ce),
`ifdef BF2_PAIR_SOF_EN
    .sof_i   (sof_i),
`endif
    .dr      (dr),
    .di      (di),
    .valid_o (valid_o),
    .ar      (ar),
    .ai      (ai),
    .br      (br),
    .bi      (bi),
    .k_o     (k_o)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: position within block plus the first-half samples.
  int           m_pos;
  logic [W-1:0] m_hr[$];
  logic [W-1:0] m_hi[$];
  logic         e_valid;
  logic [W-1:0] e_ar, e_ai, e_br, e_bi;
  logic [DL-1:0] e_k;

  task automatic model_reset();
    m_pos = 0;
    m_hr.delete();
    m_hi.delete();
    e_valid = 1'b0;
    e_ar = '0; e_ai = '0; e_br = '0; e_bi = '0; e_k = '0;
  endtask

  task automatic model_step(input logic v, input logic c, input logic s,
                            input logic [W-1:0] re, input logic [W-1:0] im);
    int kk;
    if (!c) return;
    if (!v) begin
      e_valid = 1'b0;
      return;
    end
`ifndef BF2_PAIR_SOF_EN
    s = 1'b0;
`endif
    if (s || m_pos == 0) begin
      m_hr.delete();
      m_hi.delete();
    end
    if (s) begin
      m_hr.push_back(re); m_hi.push_back(im);
      m_pos = 1;
      e_valid = 1'b0;
    end else if (m_pos < D) begin
      m_hr.push_back(re); m_hi.push_back(im);
      m_pos = m_pos + 1;
      e_valid = 1'b0;
    end else begin
      kk = m_pos - D;
      e_ar = m_hr[kk]; e_ai = m_hi[kk];
      e_br = re;       e_bi = im;
      e_k  = kk[DL-1:0];
      e_valid = 1'b1;
      m_pos = (m_pos + 1) % (2 * D);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all();
    chk("valid_o", {15'd0, valid_o}, {15'd0, e_valid});
    chk("ar", {8'd0, ar}, {8'd0, e_ar});
    chk("ai", {8'd0, ai}, {8'd0, e_ai});
    chk("br", {8'd0, br}, {8'd0, e_br});
    chk("bi", {8'd0, bi}, {8'd0, e_bi});
    chk("k_o", {14'd0, k_o}, {14'd0, e_k});
  endtask

  // One clock: drive inputs, model the edge, sample 1 time unit later.
  task automatic cyc(input logic v, input logic c, input logic s,
                     input logic [W-1:0] re, input logic [W-1:0] im);
    valid_i = v; ce = c; sof_i = s; dr = re; di = im;
    @(posedge CLK);
    model_step(v, c, s, re, im);
    #1;
    check_all();
  endtask

  task automatic feed(input int val, input int max_gap);
    int g;
    logic [W-1:0] re, im;
    g = (max_gap == 0) ? 0 : $urandom_range(1, max_gap);
    for (int i = 0; i < g; i++) cyc(1'b0, 1'b1, 1'b0, W'($urandom), W'($urandom));
    re = W'(val);
    im = W'(-val);
    cyc(1'b1, 1'b1, 1'b0, re, im);
  endtask

  // Asserts reset between edges and checks outputs clear without a clock.
  task automatic async_reset();
    valid_i = 1'b0;
    #2 RST = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    #1;
    check_all();
    #2 RST = 1'b1;
  endtask

  initial begin
    model_reset();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    #2 RST = 1'b1;

    // Back-to-back block 1..8
    for (int v = 1; v <= 8; v++) feed(v, 0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);

    // Same stream with 1..3 cycle gaps, then 9..16 across the wrap
    for (int v = 1; v <= 16; v++) feed(v, 3);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);

    // ce stall right after the second pair
    for (int v = 1; v <= 6; v++) feed(v, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'($urandom), 1'b0, 1'b0, W'($urandom), W'($urandom));
      chk("stall_valid", {15'd0, valid_o}, 16'd1);
      chk("stall_ar", {8'd0, ar}, 16'd2);
      chk("stall_br", {8'd0, br}, 16'd6);
      chk("stall_k", {14'd0, k_o}, 16'd1);
    end
    feed(7, 0);
    feed(8, 0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);

    // Signed extremes
    for (int i = 0; i < D; i++) cyc(1'b1, 1'b1, 1'b0, 8'h80, W'($urandom));
    for (int i = 0; i < D; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'h7f, W'($urandom));
      chk("ext_ar", {8'd0, ar}, 16'h0080);
      chk("ext_br", {8'd0, br}, 16'h007f);
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);

    // Reset mid-block after 6 accepts, then a clean block 11..18
    for (int v = 1; v <= 6; v++) feed(v, 0);
    async_reset();
    for (int v = 11; v <= 18; v++) feed(v, 0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);

`ifdef BF2_PAIR_SOF_EN
    // Abandoned partial block then sof-aligned block 21..28
    async_reset();
    for (int v = 1; v <= 3; v++) feed(v, 0);
    cyc(1'b1, 1'b1, 1'b1, 8'd21, 8'(-21));
    for (int v = 22; v <= 28; v++) feed(v, 0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    // sof while not accepted is ignored
    cyc(1'b0, 1'b1, 1'b1, 8'h55, 8'h55);
    cyc(1'b1, 1'b0, 1'b1, 8'h66, 8'h66);
`endif

    // Random traffic with valid/ce gaps (and occasional sof)
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
`ifdef BF2_PAIR_SOF_EN
          ($urandom_range(0, 19) == 0),
`else
          1'b0,
`endif
          W'($urandom), W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
